// File: rtl/midi_note_tx_pkg.sv
// Shared MIDI note-path definitions (transmit side and receive-side parser).
// Holds payload widths, note command nibbles, the default bit period, the
// message FSM state type, the latched note payload and a status-byte helper.
package midi_note_tx_pkg;

    localparam int unsigned MIDI_PAYLOAD_BITS = 8;
    localparam int unsigned MIDI_CH_BITS      = 3;
    localparam int unsigned MIDI_DATA_BITS    = 7;
    localparam int unsigned MIDI_CLKS_PER_BIT = 384;   // 12 MHz / 31250 baud
    localparam int unsigned MIDI_FRAME_BITS   = 10;    // start + 8 data + stop

    localparam logic [3:0] MIDI_CMD_NOTE_ON  = 4'b1001;
    localparam logic [3:0] MIDI_CMD_NOTE_OFF = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STATUS,
        ST_NOTE,
        ST_VEL
    } tx_state_e;

    // Data bytes held for the duration of one message
    typedef struct packed {
        logic [MIDI_DATA_BITS-1:0] note;
        logic [MIDI_DATA_BITS-1:0] vel;
    } note_payload_t;

    function automatic logic [MIDI_PAYLOAD_BITS-1:0] midi_status_byte(
        input logic [3:0]              cmd,
        input logic [MIDI_CH_BITS-1:0] ch
    );
        return {cmd, 1'b0, ch};
    endfunction

endpackage

// File: rtl/midi_note_tx_if.sv
// Note request bus between voice/sequencer logic (master) and midi_note_tx
// (slave).
//   ch_i, note_i, vel_i           : message fields, sampled on an accepted strobe
//   noteOnStrb_i, noteOffStrb_i   : 1-cycle send requests
//   busy_o                        : message in progress, strobes dropped
//   byteDone_o                    : 1-cycle pulse at the end of each stop bit
interface midi_note_tx_if;
    import midi_note_tx_pkg::*;

    logic [MIDI_CH_BITS-1:0]      ch_i;
    logic [MIDI_PAYLOAD_BITS-1:0] note_i;
    logic [MIDI_DATA_BITS-1:0]    vel_i;
    logic                         noteOnStrb_i;
    logic                         noteOffStrb_i;
    logic                         busy_o;
    logic                         byteDone_o;

    modport master (
        output ch_i, note_i, vel_i, noteOnStrb_i, noteOffStrb_i,
        input  busy_o, byteDone_o
    );

    modport slave (
        input  ch_i, note_i, vel_i, noteOnStrb_i, noteOffStrb_i,
        output busy_o, byteDone_o
    );

endinterface

// File: rtl/midi_uart_tx.sv
// MIDI UART byte serializer: 8N1, LSB first, idle high.
//   clk_i, nrst_i : clock, asynchronous active-low reset
//   data, valid   : byte to send; taken when valid && ready_c
//   ready_c       : idle, or in the last cycle of a stop bit (back-to-back load)
//   tx            : serial output (registered)
//   done          : 1-cycle pulse during the last cycle of each stop bit
module midi_uart_tx
    import midi_note_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = MIDI_CLKS_PER_BIT
) (
    input  logic                         clk_i,
    input  logic                         nrst_i,
    input  logic [MIDI_PAYLOAD_BITS-1:0] data,
    input  logic                         valid,
    output logic                         ready_c,
    output logic                         tx,
    output logic                         done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [3:0]       BIT_STOP = 4'(MIDI_FRAME_BITS - 1);
    localparam logic [3:0]       BIT_D7   = 4'd8;

    logic                         active_q;
    logic [CNT_W-1:0]             baud_cnt_q;
    logic [3:0]                   bit_idx_q;
    logic [MIDI_PAYLOAD_BITS-1:0] data_q;
    logic                         tx_q;
    logic                         done_q;
    logic                         last_c;

    // Final cycle of the stop bit: frame ends, next byte may start now
    assign last_c  = active_q && (bit_idx_q == BIT_STOP) && (baud_cnt_q == CNT_LAST);
    assign ready_c = !active_q || last_c;
    assign tx      = tx_q;
    assign done    = done_q;

    // Baud counter, bit index and serial output
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            active_q   <= 1'b0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            // Registered one cycle early so the pulse lands on the stop bit's last cycle
            done_q <= active_q && (bit_idx_q == BIT_STOP) && (baud_cnt_q == CNT_PRE);
            if (valid && ready_c) begin
                active_q   <= 1'b1;
                baud_cnt_q <= '0;
                bit_idx_q  <= '0;
                data_q     <= data;
                tx_q       <= 1'b0;
            end else if (active_q) begin
                if (baud_cnt_q == CNT_LAST) begin
                    baud_cnt_q <= '0;
                    if (bit_idx_q == BIT_STOP) begin
                        active_q  <= 1'b0;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b1;
                    end else begin
                        bit_idx_q <= bit_idx_q + 4'd1;
                        // Index n is leaving; bit n+1 is d(n) until d7, then stop
                        tx_q      <= (bit_idx_q < BIT_D7) ? data_q[bit_idx_q[2:0]] : 1'b1;
                    end
                end else begin
                    baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/midi_note_tx.sv
// MIDI note transmitter: turns note-on/off strobes into 3-byte channel voice
// messages (status, note, velocity) and serializes them via midi_uart_tx.
//   clk_i, nrst_i : clock, asynchronous active-low reset
//   note_bus      : midi_note_tx_if.slave (fields, strobes, busy_o, byteDone_o)
//   tx_o          : MIDI OUT serial line
// Build option MIDI_RUNNING_STATUS_EN: remember the last status byte and skip
// it when the next message repeats it (2-byte message).
module midi_note_tx
    import midi_note_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = MIDI_CLKS_PER_BIT
) (
    input  logic           clk_i,
    input  logic           nrst_i,
    midi_note_tx_if.slave  note_bus,
    output logic           tx_o
);

    tx_state_e                    state_q;
    tx_state_e                    state_d;
    note_payload_t                payload_q;
    logic                         busy_q;
    logic                         accept_c;
    logic                         strobe_c;
    logic                         skip_status_c;
    logic [MIDI_PAYLOAD_BITS-1:0] status_c;
    logic [MIDI_PAYLOAD_BITS-1:0] uart_data_c;
    logic                         uart_valid_c;
    logic                         uart_ready_c;
    logic                         byte_done;
    logic                         unused_note_msb;

    // Note Off has priority when both strobes arrive together
    assign strobe_c = note_bus.noteOnStrb_i || note_bus.noteOffStrb_i;
    assign status_c = midi_status_byte(
        note_bus.noteOffStrb_i ? MIDI_CMD_NOTE_OFF : MIDI_CMD_NOTE_ON, note_bus.ch_i);
    assign unused_note_msb = note_bus.note_i[MIDI_PAYLOAD_BITS-1];

`ifdef MIDI_RUNNING_STATUS_EN
    logic [MIDI_PAYLOAD_BITS-1:0] last_status_q;

    // Last status byte put on the wire; 0x00 never matches a real status
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            last_status_q <= '0;
        end else if (accept_c) begin
            last_status_q <= status_c;
        end
    end

    assign skip_status_c = (status_c == last_status_q);
`else
    assign skip_status_c = 1'b0;
`endif

    // Message FSM state register
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and byte handoff; each state advances on its byte's last stop cycle
    always_comb begin
        state_d      = state_q;
        accept_c     = 1'b0;
        uart_valid_c = 1'b0;
        uart_data_c  = '0;
        case (state_q)
            ST_IDLE: begin
                if (strobe_c) begin
                    accept_c     = 1'b1;
                    uart_valid_c = 1'b1;
                    if (skip_status_c) begin
                        state_d     = ST_NOTE;
                        uart_data_c = {1'b0, note_bus.note_i[MIDI_DATA_BITS-1:0]};
                    end else begin
                        state_d     = ST_STATUS;
                        uart_data_c = status_c;
                    end
                end
            end
            ST_STATUS: begin
                if (uart_ready_c) begin
                    state_d      = ST_NOTE;
                    uart_valid_c = 1'b1;
                    uart_data_c  = {1'b0, payload_q.note};
                end
            end
            ST_NOTE: begin
                if (uart_ready_c) begin
                    state_d      = ST_VEL;
                    uart_valid_c = 1'b1;
                    uart_data_c  = {1'b0, payload_q.vel};
                end
            end
            ST_VEL: begin
                if (uart_ready_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Payload latch and busy flag
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            payload_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= (state_d != ST_IDLE);
            if (accept_c) begin
                payload_q.note <= note_bus.note_i[MIDI_DATA_BITS-1:0];
                payload_q.vel  <= note_bus.vel_i;
            end
        end
    end

    assign note_bus.busy_o     = busy_q;
    assign note_bus.byteDone_o = byte_done;

    midi_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .data    (uart_data_c),
        .valid   (uart_valid_c),
        .ready_c (uart_ready_c),
        .tx      (tx_o),
        .done    (byte_done)
    );

endmodule

// File: tb/tb_midi_note_tx.sv
// Directed bench for midi_note_tx with CLKS_PER_BIT = 4. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_midi_note_tx;
    import midi_note_tx_pkg::*;

    localparam int C        = 4;
    localparam int BYTE_CYC = 10 * C;

    logic clk = 1'b0;
    logic nrst;
    logic tx;
    int   checks = 0;
    int   errors = 0;

    midi_note_tx_if bus ();

    midi_note_tx #(.CLKS_PER_BIT(C)) dut (
        .clk_i    (clk),
        .nrst_i   (nrst),
        .note_bus (bus),
        .tx_o     (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.noteOnStrb_i  = 1'b0;
        bus.noteOffStrb_i = 1'b0;
    endtask

    // Drive a request for one cycle; returns at the falling edge of the cycle after
    task automatic strobe(input logic on, input logic off, input logic [2:0] ch,
                          input logic [7:0] note, input logic [6:0] vel);
        bus.ch_i          = ch;
        bus.note_i        = note;
        bus.vel_i         = vel;
        bus.noteOnStrb_i  = on;
        bus.noteOffStrb_i = off;
        @(negedge clk);
        idle_inputs();
    endtask

    // Check a whole message starting at the cycle after acceptance; optionally
    // inject a noteOn strobe at cycle index inj
    task automatic check_msg(input string tag, input int nbytes, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2, input int inj);
        logic [7:0] bytes [3];
        int busy_cnt;
        int done_cnt;
        int done_bad;
        int n;
        logic e;
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        busy_cnt = 0;
        done_cnt = 0;
        done_bad = 0;
        n = nbytes * BYTE_CYC;
        for (int i = 0; i < n; i++) begin
            int j;
            int k;
            j = i / BYTE_CYC;
            k = (i / C) % 10;
            if (bus.busy_o === 1'b1) busy_cnt++;
            if (bus.byteDone_o === 1'b1) done_cnt++;
            if ((bus.byteDone_o === 1'b1) != ((i % BYTE_CYC) == BYTE_CYC - 1)) done_bad++;
            if (i % C == C / 2) begin
                if (k == 0)      e = 1'b0;
                else if (k == 9) e = 1'b1;
                else             e = bytes[j][k-1];
                check($sformatf("%s byte%0d bit%0d", tag, j, k), 32'(tx), 32'(e));
            end
            if (i == inj) begin
                bus.ch_i         = 3'd6;
                bus.note_i       = 8'h11;
                bus.vel_i        = 7'h22;
                bus.noteOnStrb_i = 1'b1;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(n));
        check({tag, " done_count"}, 32'(done_cnt), 32'(nbytes));
        check({tag, " done_position"}, 32'(done_bad), 32'd0);
        check({tag, " busy_end"}, 32'(bus.busy_o), 32'd0);
        check({tag, " tx_idle"}, 32'(tx), 32'd1);
    endtask

    initial begin
        int stray;
        nrst = 1'b0;
        bus.ch_i   = '0;
        bus.note_i = '0;
        bus.vel_i  = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset byteDone", 32'(bus.byteDone_o), 32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: note on ch3
        check("t1 tx_before", 32'(tx), 32'd1);
        strobe(1'b1, 1'b0, 3'd3, 8'h3C, 7'h64);
        check("t1 tx_fall", 32'(tx), 32'd0);
        check("t1 busy_rise", 32'(bus.busy_o), 32'd1);
        check_msg("t1", 3, 8'h93, 8'h3C, 8'h64, -1);

        // 2: note off ch0, note MSB masked
        strobe(1'b0, 1'b1, 3'd0, 8'hBC, 7'h00);
        check_msg("t2", 3, 8'h80, 8'h3C, 8'h00, -1);

        // 3: strobe during the NOTE byte is dropped
        strobe(1'b1, 1'b0, 3'd1, 8'h45, 7'h33);
        check_msg("t3", 3, 8'h91, 8'h45, 8'h33, BYTE_CYC + 5);
        stray = 0;
        for (int i = 0; i < 2 * C; i++) begin
            if (tx !== 1'b1 || bus.busy_o !== 1'b0) stray++;
            @(negedge clk);
        end
        check("t3 no_extra", 32'(stray), 32'd0);

        // 4: both strobes together, note off wins
        strobe(1'b1, 1'b1, 3'd5, 8'h01, 7'h7F);
        check_msg("t4", 3, 8'h85, 8'h01, 8'h7F, -1);

        // 5: reset in the middle of the NOTE byte
        strobe(1'b1, 1'b0, 3'd3, 8'h40, 7'h10);
        repeat (15 * C) @(negedge clk);
        nrst = 1'b0;
        #1;
        check("t5 abort tx", 32'(tx), 32'd1);
        check("t5 abort busy", 32'(bus.busy_o), 32'd0);
        check("t5 abort byteDone", 32'(bus.byteDone_o), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        strobe(1'b1, 1'b0, 3'd3, 8'h40, 7'h10);
        check_msg("t5", 3, 8'h93, 8'h40, 8'h10, -1);

        // 6: two identical-status messages back to back; second strobe lands
        // in the first idle cycle
        strobe(1'b1, 1'b0, 3'd2, 8'h3C, 7'h40);
        check_msg("t6a", 3, 8'h92, 8'h3C, 8'h40, -1);
        strobe(1'b1, 1'b0, 3'd2, 8'h3C, 7'h40);
        check("t6b tx_fall", 32'(tx), 32'd0);
`ifdef MIDI_RUNNING_STATUS_EN
        check_msg("t6b", 2, 8'h3C, 8'h40, 8'h00, -1);
`else
        check_msg("t6b", 3, 8'h92, 8'h3C, 8'h40, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
